// File: rtl/vga_pkg.sv
// Shared display geometry, colours and frame-store address helper for the
// 640x480 monochrome pixel buffer.
package vga_pkg;

  localparam int H_VISIBLE  = 640;
  localparam int V_VISIBLE  = 480;
  localparam int H_TOTAL    = 800;
  localparam int V_TOTAL    = 525;
  localparam int WORDS_LINE = 40;
  localparam int GROUP_W    = 16;

  localparam logic [17:0] BASE_ADDR = 18'h0;
  localparam logic [7:0]  FG_COLOR  = 8'hFF;
  localparam logic [7:0]  BG_COLOR  = 8'h00;

  // word(row, grp) = BASE_ADDR + row*40 + grp; row*40 built from two shifts
  // so no multiplier is inferred. Largest value is 479*40+39 = 19199.
  function automatic logic [17:0] word_addr(input logic [9:0] row, input logic [5:0] grp);
    logic [17:0] row_ext;
    row_ext = {8'd0, row};
    return BASE_ADDR + (row_ext << 5) + (row_ext << 3) + {12'd0, grp};
  endfunction

endpackage

// File: rtl/vga_pixel_buffer_fetch_ctrl.sv
// Prefetch controller: decodes fetch points from the beam counters, forms the
// SRAM word address and runs the single-outstanding read/ready handshake.
module pb_fetch_ctrl
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] i_hcounter,
  input  logic [9:0]  i_vcounter,
  output logic [17:0] o_address,
  output logic        o_read,
  input  logic        i_ready,
  input  logic [15:0] i_data_read,
  output logic [15:0] o_next_word
);

  logic        w_grp_hit;
  logic        w_line_hit;
  logic        w_trigger;
  logic [9:0]  w_row;
  logic [5:0]  w_grp;
  logic [17:0] w_addr;

  logic [17:0] r_address;
  logic        r_read;
  logic [15:0] r_next_word;

  // Group starts 0..38 on visible rows fetch the following group; the last
  // group (h=624) has nothing to prefetch on this line. The h<624 bound also
  // rejects out-of-range counters whose low nibble happens to be zero.
  assign w_grp_hit  = (i_hcounter[3:0] == 4'd0)
                   && (i_hcounter < 11'(H_VISIBLE - GROUP_W))
                   && (i_vcounter < 10'(V_VISIBLE));

  // Sixteen clocks before line end, fetch group 0 of the next displayed row:
  // the next visible row, or row 0 when leaving the last line of the frame.
  assign w_line_hit = (i_hcounter == 11'(H_TOTAL - GROUP_W))
                   && ((i_vcounter < 10'(V_VISIBLE - 1)) || (i_vcounter == 10'(V_TOTAL - 1)));

  assign w_trigger  = w_grp_hit | w_line_hit;

  // Row/group selection for whichever trigger is active
  always_comb begin
    w_row = i_vcounter;
    w_grp = i_hcounter[9:4] + 6'd1;
    if (w_line_hit) begin
      w_row = (i_vcounter == 10'(V_TOTAL - 1)) ? 10'd0 : i_vcounter + 10'd1;
      w_grp = 6'd0;
    end
  end

  assign w_addr = word_addr(w_row, w_grp);

  // Single outstanding read: a trigger while a read is pending is dropped,
  // and ready outside a pending read is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_address   <= 18'd0;
      r_read      <= 1'b0;
      r_next_word <= 16'd0;
    end else if (w_trigger && !r_read) begin
      r_address <= w_addr;
      r_read    <= 1'b1;
    end else if (r_read && i_ready) begin
      r_next_word <= i_data_read;
      r_read      <= 1'b0;
    end
  end

  assign o_address   = r_address;
  assign o_read      = r_read;
  assign o_next_word = r_next_word;

endmodule

// File: rtl/vga_pixel_buffer.sv
// Pixel buffer top: prefetch controller plus the 16-pixel serialiser. pixels
// always reflects the column presented on hcounter one clock earlier.
module vga_pixel_buffer
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] hcounter,
  input  logic [9:0]  vcounter,
  output logic [17:0] address,
  output logic        read,
  input  logic        ready,
  input  logic [15:0] data_read,
  output logic [7:0]  pixels
);

  logic [15:0] w_next_word;
  logic        w_visible;
  logic [3:0]  w_bit_sel;
  logic        w_pix_bit;

  logic [15:0] r_cur_word;
  logic [7:0]  r_pixels;

  pb_fetch_ctrl u_fetch (
    .clk         (clk),
    .reset       (reset),
    .i_hcounter  (hcounter),
    .i_vcounter  (vcounter),
    .o_address   (address),
    .o_read      (read),
    .i_ready     (ready),
    .i_data_read (data_read),
    .o_next_word (w_next_word)
  );

  assign w_visible = (hcounter < 11'(H_VISIBLE)) && (vcounter < 10'(V_VISIBLE));
  assign w_bit_sel = hcounter[3:0];
  assign w_pix_bit = r_cur_word[4'd15 - w_bit_sel];

  // Serialise: load a new word at each group start (showing its MSB at once),
  // otherwise walk the held word MSB-first; blank outside the visible area.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur_word <= 16'd0;
      r_pixels   <= 8'd0;
    end else if (w_visible) begin
      if (w_bit_sel == 4'd0) begin
        r_cur_word <= w_next_word;
        r_pixels   <= w_next_word[15] ? FG_COLOR : BG_COLOR;
      end else begin
        r_pixels   <= w_pix_bit ? FG_COLOR : BG_COLOR;
      end
    end else begin
      r_pixels <= BG_COLOR;
    end
  end

  assign pixels = r_pixels;

endmodule

// File: tb/tb_vga_pixel_buffer.sv
// Bench for vga_pixel_buffer: directed counter sequences, a behavioural SRAM
// with programmable ready delay, and queue-based scoreboards for pixels and
// read addresses.
module tb_vga_pixel_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] hcounter;
  logic [9:0]  vcounter;
  logic [17:0] address;
  logic        read;
  logic        ready;
  logic [15:0] data_read;
  logic [7:0]  pixels;

  vga_pixel_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .hcounter  (hcounter),
    .vcounter  (vcounter),
    .address   (address),
    .read      (read),
    .ready     (ready),
    .data_read (data_read),
    .pixels    (pixels)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // SRAM model state
  int          sram_cnt   = 0;
  int          sram_delay = 4;
  logic [15:0] sram_data  = 16'h1234;
  bit          sram_rand  = 1'b1;
  bit          stray      = 1'b0;

  // Reference model state
  logic [15:0] m_next = 16'd0;
  logic [15:0] m_cur  = 16'd0;
  bit          m_pend = 1'b0;
  logic [17:0] m_addr = 18'd0;

  logic [7:0]  pix_q[$];
  logic [17:0] addr_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h (h=%0d v=%0d t=%0t)", tag, got, exp, hcounter, vcounter, $time);
    end
  endtask

  function automatic logic [7:0] col(input logic b);
    return b ? 8'hFF : 8'h00;
  endfunction

  function automatic logic [17:0] word(input int row, input int g);
    return 18'(row * 40 + g);
  endfunction

  // One pixel clock: drive counters and SRAM response, predict, then check.
  task automatic tick(input int h, input int v);
    logic [7:0]  exp_pix;
    logic [15:0] new_cur;
    logic        trig;
    logic [17:0] taddr;
    logic        give;
    logic        prev_read;

    hcounter = h[10:0];
    vcounter = v[9:0];

    give = 1'b0;
    if (!reset && read) begin
      sram_cnt++;
      give = (sram_cnt >= sram_delay);
    end else begin
      sram_cnt = 0;
    end
    if (stray && !read) begin
      ready     = 1'b1;
      data_read = 16'hDEAD;
    end else begin
      ready     = give;
      data_read = give ? sram_data : 16'h5A5A;
    end

    new_cur = m_cur;
    if (reset) exp_pix = 8'h00;
    else if (h < 640 && v < 480) begin
      if (h % 16 == 0) begin
        exp_pix = col(m_next[15]);
        new_cur = m_next;
      end else begin
        exp_pix = col(m_cur[15 - (h % 16)]);
      end
    end else exp_pix = 8'h00;
    pix_q.push_back(exp_pix);

    trig  = 1'b0;
    taddr = 18'd0;
    if (h < 624 && h % 16 == 0 && v < 480) begin
      trig  = 1'b1;
      taddr = word(v, h / 16 + 1);
    end else if (h == 784 && (v < 479 || v == 524)) begin
      trig  = 1'b1;
      taddr = word((v == 524) ? 0 : v + 1, 0);
    end

    if (reset) begin
      m_next = 16'd0;
      m_cur  = 16'd0;
      m_pend = 1'b0;
      addr_q.delete();
    end else begin
      m_cur = new_cur;
      if (trig && !m_pend) begin
        addr_q.push_back(taddr);
        m_addr = taddr;
        m_pend = 1'b1;
      end else if (m_pend && give) begin
        m_next = sram_data;
        m_pend = 1'b0;
      end
    end

    prev_read = read;
    @(posedge clk);
    #1;

    chk("pixels", 32'(pixels), 32'(pix_q.pop_front()));
    chk("read", 32'(read), 32'(m_pend));
    if (read && !prev_read && addr_q.size() > 0)
      chk("addr_issue", 32'(address), 32'(addr_q.pop_front()));
    if (m_pend) chk("addr_hold", 32'(address), 32'(m_addr));
    if (reset)  chk("rst_addr", 32'(address), 32'd0);
    if (give && sram_rand) sram_data = 16'($urandom);
    ready = 1'b0;
  endtask

  task automatic run_line(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) tick(h, v);
  endtask

  initial begin
    reset     = 1'b1;
    hcounter  = 11'd0;
    vcounter  = 10'd0;
    ready     = 1'b0;
    data_read = 16'd0;

    // 1: reset held 8 cycles on a trigger position, then first fetch
    for (int i = 0; i < 8; i++) tick(0, 0);
    reset = 1'b0;
    tick(0, 0);
    chk("t1_first_read", 32'(read), 32'd1);
    chk("t1_first_addr", 32'(address), 32'd1);
    run_line(0, 1, 10);

    // 2: end-of-frame fetch of row 0, then the 8001 pattern on row 0
    sram_rand = 1'b0;
    sram_data = 16'h8001;
    run_line(524, 780, 784);
    chk("t2_read", 32'(read), 32'd1);
    chk("t2_addr", 32'(address), 32'd0);
    run_line(524, 785, 799);
    sram_data = 16'hF0F0;
    tick(0, 0);
    chk("t2_h0", 32'(pixels), 32'hFF);
    run_line(0, 1, 14);
    chk("t2_h14", 32'(pixels), 32'h00);
    tick(15, 0);
    chk("t2_h15", 32'(pixels), 32'hFF);
    sram_rand = 1'b1;
    run_line(0, 16, 799);

    // 3: addresses on row 10, nothing at h=624, next line at h=784
    run_line(9, 780, 799);
    tick(0, 10);
    chk("t3_a401", 32'(address), 32'd401);
    run_line(10, 1, 16);
    chk("t3_a402", 32'(address), 32'd402);
    run_line(10, 17, 608);
    chk("t3_a439", 32'(address), 32'd439);
    run_line(10, 609, 624);
    chk("t3_no624", 32'(read), 32'd0);
    run_line(10, 625, 784);
    chk("t3_a440", 32'(address), 32'd440);
    run_line(10, 785, 799);
    tick(900, 10);
    tick(1024, 0);
    chk("oor_noread", 32'(read), 32'd0);

    // 4: slow SRAM (10 cycles held), FFFF shown on the next group
    run_line(19, 780, 799);
    sram_rand  = 1'b0;
    sram_delay = 11;
    sram_data  = 16'hFFFF;
    run_line(20, 0, 16);
    chk("t4_ffff", 32'(pixels), 32'hFF);
    run_line(20, 17, 31);
    chk("t4_ffff_end", 32'(pixels), 32'hFF);
    sram_delay = 4;
    stray = 1'b1;
    run_line(20, 32, 40);
    stray = 1'b0;
    sram_rand = 1'b1;
    run_line(20, 41, 799);

    // 5: blanking with non-zero prefetched data; no fetch after row 479
    sram_rand = 1'b0;
    sram_data = 16'hFFFF;
    run_line(30, 0, 799);
    run_line(479, 770, 784);
    chk("t5_no479", 32'(read), 32'd0);
    run_line(479, 785, 799);
    run_line(480, 0, 40);
    chk("t5_vblank", 32'(pixels), 32'h00);
    run_line(500, 0, 40);

    // 6: ready withheld 20 cycles -> stale group, dropped trigger, late word
    sram_data = 16'h0000;
    run_line(39, 780, 799);
    sram_delay = 21;
    sram_data  = 16'hFFFF;
    run_line(40, 0, 16);
    chk("t6_stale", 32'(pixels), 32'h00);
    tick(17, 40);
    chk("t6_drop_addr", 32'(address), 32'd1601);
    run_line(40, 18, 32);
    chk("t6_late", 32'(pixels), 32'hFF);
    sram_delay = 4;
    sram_rand  = 1'b1;
    run_line(40, 33, 100);

    // 7: reset in the middle of a pending read
    sram_delay = 11;
    run_line(50, 0, 2);
    reset = 1'b1;
    tick(3, 50);
    chk("t7_rst_read", 32'(read), 32'd0);
    reset = 1'b0;
    sram_delay = 4;
    run_line(50, 4, 60);

    chk("addr_q_left", 32'(addr_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
